maj_layer: RTL and testbench

Parametrised, registered layer of NUM_NEURONS binary majority perceptrons. Each neuron is fully connected to FAN_IN input bits through per-neuron XNOR weight bits and has a per-neuron control (tie-break) bit. The layer runs a forward pass and a backward pass, each behind a valid/ready handshake, with optional on-chip learning. Layers chain into the bitnet datapath: fwd_data_out feeds the next layer's fwd_data_in, and bwd_data_out feeds the previous layer's bwd_data_in.

---
 rtl/maj_layer.sv | 179 +++++++++++++++++
 tb/tb_maj_layer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_layer.sv
// rtl/maj_layer.sv - registered layer of binary majority perceptrons with fwd/bwd handshakes
// Forward computes y from x; backward back-projects targets d and can retrain weights.
module maj_layer #(
  parameter int FAN_IN      = 3,
  parameter int NUM_NEURONS = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   fwd_valid_in,
  output logic                   fwd_ready_out,
  input  logic [FAN_IN-1:0]      fwd_data_in,
  output logic                   fwd_valid_out,
  input  logic                   fwd_ready_in,
  output logic [NUM_NEURONS-1:0] fwd_data_out,
  input  logic                   bwd_valid_in,
  output logic                   bwd_ready_out,
  input  logic [NUM_NEURONS-1:0] bwd_data_in,
  output logic                   bwd_valid_out,
  input  logic                   bwd_ready_in,
  output logic [FAN_IN-1:0]      bwd_data_out,
  input  logic                   learn_en_in,
  input  logic                   wr_en_in,
  input  logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] wr_addr_in,
  input  logic [FAN_IN-1:0]      wr_weights_in,
  input  logic                   wr_ctrl_in
);

  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD_HOLD = 2'd1,
    WAIT_BWD = 2'd2,
    BWD_HOLD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [FAN_IN-1:0]      w_q [NUM_NEURONS];
  logic [FAN_IN-1:0]      w_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] ctrl_q, ctrl_d;
  logic [FAN_IN-1:0]      x_q, x_d;
  logic [NUM_NEURONS-1:0] y_q, y_d;
  logic [NUM_NEURONS-1:0] fwd_data_q, fwd_data_d;
  logic [FAN_IN-1:0]      bwd_data_q, bwd_data_d;

  logic                   fwd_accept;
  logic                   bwd_accept;
  logic                   wr_hit;
  logic [NUM_NEURONS-1:0] y_new;
  logic [FAN_IN-1:0]      b_new;

  // Majority of x XNOR w; an exact half vote takes the neuron's tie bit.
  function automatic logic neuron_eval(input logic [FAN_IN-1:0] x,
                                       input logic [FAN_IN-1:0] w,
                                       input logic              tie);
    int s;
    s = 0;
    for (int i = 0; i < FAN_IN; i++) begin
      if (x[i] == w[i]) s++;
    end
    if (2 * s > FAN_IN) return 1'b1;
    if (2 * s == FAN_IN) return tie;
    return 1'b0;
  endfunction

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fwd_valid_in) state_d = FWD_HOLD;
      FWD_HOLD: if (fwd_ready_in) state_d = WAIT_BWD;
      WAIT_BWD: if (bwd_valid_in) state_d = BWD_HOLD;
      BWD_HOLD: if (bwd_ready_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fwd_ready_out = (state_q == IDLE);
    bwd_ready_out = (state_q == WAIT_BWD);
    fwd_valid_out = (state_q == FWD_HOLD);
    bwd_valid_out = (state_q == BWD_HOLD);
    fwd_data_out  = fwd_data_q;
    bwd_data_out  = bwd_data_q;
  end

  assign fwd_accept = (state_q == IDLE) && fwd_valid_in;
  assign bwd_accept = (state_q == WAIT_BWD) && bwd_valid_in;
  assign wr_hit     = (state_q == IDLE) && wr_en_in && (int'(wr_addr_in) < NUM_NEURONS);

  // Forward evaluation always sees the registered (pre-write) weights.
  always_comb begin
    y_new = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      y_new[n] = neuron_eval(fwd_data_in, w_q[n], ctrl_q[n]);
    end
  end

  // Backward vote per input column k over all neurons; ties fall back to the saved input.
  always_comb begin
    int cnt;
    b_new = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      cnt = 0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (bwd_data_in[n] == w_q[n][k]) cnt++;
      end
      if (2 * cnt > NUM_NEURONS)       b_new[k] = 1'b1;
      else if (2 * cnt == NUM_NEURONS) b_new[k] = x_q[k];
      else                             b_new[k] = 1'b0;
    end
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    fwd_data_d = fwd_data_q;
    bwd_data_d = bwd_data_q;
    ctrl_d     = ctrl_q;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      w_d[n] = w_q[n];
    end

    if (fwd_accept) begin
      x_d        = fwd_data_in;
      y_d        = y_new;
      fwd_data_d = y_new;
    end

    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (wr_hit && (wr_addr_in == AW'(n))) begin
        w_d[n]    = wr_weights_in;
        ctrl_d[n] = wr_ctrl_in;
      end
    end

    if (bwd_accept) begin
      bwd_data_d = b_new;
      // Only neurons that answered wrongly are retrained, toward d XNOR x.
      if (learn_en_in) begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
          if (bwd_data_in[n] != y_q[n]) begin
            w_d[n] = bwd_data_in[n] ? x_q : ~x_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        w_q[n] <= '1;
      end
      ctrl_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fwd_data_q <= '0;
      bwd_data_q <= '0;
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        w_q[n] <= w_d[n];
      end
      ctrl_q     <= ctrl_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fwd_data_q <= fwd_data_d;
      bwd_data_q <= bwd_data_d;
    end
  end

endmodule

// File: tb/tb_maj_layer.sv
// tb/tb_maj_layer.sv - scoreboard bench for maj_layer
// Stimulus pushes expected results; a negedge monitor pops them on each output handshake.
module tb_maj_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in;
  logic       fwd_valid_in, fwd_ready_out, fwd_valid_out, fwd_ready_in;
  logic [2:0] fwd_data_in, fwd_data_out;
  logic       bwd_valid_in, bwd_ready_out, bwd_valid_out, bwd_ready_in;
  logic [2:0] bwd_data_in, bwd_data_out;
  logic       learn_en_in, wr_en_in, wr_ctrl_in;
  logic [1:0] wr_addr_in;
  logic [2:0] wr_weights_in;

  logic       b_fwd_valid_in, b_fwd_ready_out, b_fwd_valid_out, b_fwd_ready_in;
  logic [3:0] b_fwd_data_in;
  logic [2:0] b_fwd_data_out;
  logic       b_bwd_valid_in, b_bwd_ready_out, b_bwd_valid_out, b_bwd_ready_in;
  logic [2:0] b_bwd_data_in;
  logic [3:0] b_bwd_data_out;
  logic       b_wr_en_in, b_wr_ctrl_in;
  logic [1:0] b_wr_addr_in;
  logic [3:0] b_wr_weights_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] fq[$];
  logic [2:0] bq[$];
  logic [2:0] q4[$];

  maj_layer #(.FAN_IN(3), .NUM_NEURONS(3)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .fwd_valid_in(fwd_valid_in), .fwd_ready_out(fwd_ready_out), .fwd_data_in(fwd_data_in),
    .fwd_valid_out(fwd_valid_out), .fwd_ready_in(fwd_ready_in), .fwd_data_out(fwd_data_out),
    .bwd_valid_in(bwd_valid_in), .bwd_ready_out(bwd_ready_out), .bwd_data_in(bwd_data_in),
    .bwd_valid_out(bwd_valid_out), .bwd_ready_in(bwd_ready_in), .bwd_data_out(bwd_data_out),
    .learn_en_in(learn_en_in), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
    .wr_weights_in(wr_weights_in), .wr_ctrl_in(wr_ctrl_in)
  );

  maj_layer #(.FAN_IN(4), .NUM_NEURONS(3)) dut4 (
    .clk_in(clk), .rst_in(rst_in),
    .fwd_valid_in(b_fwd_valid_in), .fwd_ready_out(b_fwd_ready_out), .fwd_data_in(b_fwd_data_in),
    .fwd_valid_out(b_fwd_valid_out), .fwd_ready_in(b_fwd_ready_in), .fwd_data_out(b_fwd_data_out),
    .bwd_valid_in(b_bwd_valid_in), .bwd_ready_out(b_bwd_ready_out), .bwd_data_in(b_bwd_data_in),
    .bwd_valid_out(b_bwd_valid_out), .bwd_ready_in(b_bwd_ready_in), .bwd_data_out(b_bwd_data_out),
    .learn_en_in(1'b0), .wr_en_in(b_wr_en_in), .wr_addr_in(b_wr_addr_in),
    .wr_weights_in(b_wr_weights_in), .wr_ctrl_in(b_wr_ctrl_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: handshake did not occur within bound at %0t", name, $time);
  endtask

  // Monitor: compare on every output handshake
  always @(negedge clk) begin
    logic [2:0] e;
    if (fwd_valid_out && fwd_ready_in) begin
      if (fq.size() == 0) timeout("fwd_unexpected");
      else begin e = fq.pop_front(); check("fwd_data", {29'd0, fwd_data_out}, {29'd0, e}); end
    end
    if (bwd_valid_out && bwd_ready_in) begin
      if (bq.size() == 0) timeout("bwd_unexpected");
      else begin e = bq.pop_front(); check("bwd_data", {29'd0, bwd_data_out[2:0]}, {29'd0, e}); end
    end
    if (b_fwd_valid_out && b_fwd_ready_in) begin
      if (q4.size() == 0) timeout("fwd4_unexpected");
      else begin e = q4.pop_front(); check("fwd4_data", {29'd0, b_fwd_data_out}, {29'd0, e}); end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_fwd_valid", {31'd0, fwd_valid_out}, 0);
    check("rst_bwd_valid", {31'd0, bwd_valid_out}, 0);
    check("rst_fwd_data", {29'd0, fwd_data_out}, 0);
    check("rst_bwd_data", {29'd0, bwd_data_out}, 0);
    check("rst_fwd_ready", {31'd0, fwd_ready_out}, 1);
    check("rst_bwd_ready", {31'd0, bwd_ready_out}, 0);
  endtask

  task automatic write(input logic [1:0] a, input logic [2:0] w, input logic c);
    @(posedge clk); #1;
    wr_en_in = 1'b1; wr_addr_in = a; wr_weights_in = w; wr_ctrl_in = c;
    @(posedge clk); #1;
    wr_en_in = 1'b0;
  endtask

  // Forward transfer; with stall>0 the result is held back and a write is attempted meanwhile.
  task automatic fwd(input logic [2:0] x, input logic [2:0] exp, input int stall);
    int t;
    @(posedge clk); #1;
    fq.push_back(exp);
    fwd_data_in = x; fwd_valid_in = 1'b1; fwd_ready_in = (stall == 0);
    t = 0;
    while (!fwd_ready_out && t < 20) begin @(negedge clk); t++; end
    if (!fwd_ready_out) timeout("fwd_accept");
    @(posedge clk); #1;
    fwd_valid_in = 1'b0; fwd_data_in = '0;
    if (stall > 0) begin
      wr_en_in = 1'b1; wr_addr_in = 2'd0; wr_weights_in = 3'b000; wr_ctrl_in = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("fwd_hold_valid", {31'd0, fwd_valid_out}, 1);
        check("fwd_hold_data", {29'd0, fwd_data_out}, {29'd0, exp});
        check("fwd_hold_ready", {31'd0, fwd_ready_out}, 0);
        @(posedge clk); #1;
      end
      wr_en_in = 1'b0; fwd_ready_in = 1'b1;
    end
    @(negedge clk);
    check("fwd_valid_lat", {31'd0, fwd_valid_out}, 1);
    @(posedge clk); #1;
    fwd_ready_in = 1'b0;
    @(negedge clk);
    check("fwd_valid_drop", {31'd0, fwd_valid_out}, 0);
    check("bwd_ready_after_fwd", {31'd0, bwd_ready_out}, 1);
  endtask

  task automatic bwd(input logic [2:0] d, input logic learn, input logic [2:0] exp, input int stall);
    int t;
    @(posedge clk); #1;
    bq.push_back(exp);
    bwd_data_in = d; learn_en_in = learn; bwd_valid_in = 1'b1; bwd_ready_in = (stall == 0);
    t = 0;
    while (!bwd_ready_out && t < 20) begin @(negedge clk); t++; end
    if (!bwd_ready_out) timeout("bwd_accept");
    @(posedge clk); #1;
    bwd_valid_in = 1'b0; learn_en_in = 1'b0; bwd_data_in = '0;
    if (stall > 0) begin
      wr_en_in = 1'b1; wr_addr_in = 2'd0; wr_weights_in = 3'b000; wr_ctrl_in = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("bwd_hold_valid", {31'd0, bwd_valid_out}, 1);
        check("bwd_hold_data", {29'd0, bwd_data_out}, {29'd0, exp});
        check("bwd_hold_ready", {31'd0, bwd_ready_out}, 0);
        check("bwd_hold_fwd_ready", {31'd0, fwd_ready_out}, 0);
        @(posedge clk); #1;
      end
      wr_en_in = 1'b0; bwd_ready_in = 1'b1;
    end
    @(negedge clk);
    check("bwd_valid_lat", {31'd0, bwd_valid_out}, 1);
    @(posedge clk); #1;
    bwd_ready_in = 1'b0;
    @(negedge clk);
    check("bwd_valid_drop", {31'd0, bwd_valid_out}, 0);
    check("fwd_ready_after_bwd", {31'd0, fwd_ready_out}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    fwd_valid_in = 0; fwd_data_in = 0; fwd_ready_in = 0;
    bwd_valid_in = 0; bwd_data_in = 0; bwd_ready_in = 0;
    learn_en_in = 0; wr_en_in = 0; wr_addr_in = 0; wr_weights_in = 0; wr_ctrl_in = 0;
    b_fwd_valid_in = 0; b_fwd_data_in = 0; b_fwd_ready_in = 0;
    b_bwd_valid_in = 0; b_bwd_data_in = 0; b_bwd_ready_in = 0;
    b_wr_en_in = 0; b_wr_addr_in = 0; b_wr_weights_in = 0; b_wr_ctrl_in = 0;

    do_reset();

    // FAN_IN=4: x=0011 ties every neuron; only neuron 1 has its tie bit set
    @(posedge clk); #1;
    b_wr_en_in = 1'b1; b_wr_addr_in = 2'd1; b_wr_weights_in = 4'hF; b_wr_ctrl_in = 1'b1;
    @(posedge clk); #1;
    b_wr_en_in = 1'b0;
    q4.push_back(3'b010);
    b_fwd_data_in = 4'b0011; b_fwd_valid_in = 1'b1; b_fwd_ready_in = 1'b1;
    @(posedge clk); #1;
    b_fwd_valid_in = 1'b0;
    @(negedge clk);
    check("fwd4_valid_lat", {31'd0, b_fwd_valid_out}, 1);

    // plain majority
    fwd(3'b011, 3'b111, 0);
    bwd(3'b111, 1'b0, 3'b111, 0);

    // neuron 0 inverted
    write(2'd0, 3'b000, 1'b0);
    fwd(3'b011, 3'b110, 0);
    bwd(3'b110, 1'b0, 3'b111, 0);

    // out-of-range write ignored
    write(2'd3, 3'b000, 1'b1);
    fwd(3'b011, 3'b110, 0);
    bwd(3'b110, 1'b0, 3'b111, 0);

    // learning retrains neuron 1 to 100
    do_reset();
    fwd(3'b011, 3'b111, 0);
    bwd(3'b101, 1'b1, 3'b111, 0);
    fwd(3'b011, 3'b101, 0);
    bwd(3'b000, 1'b0, 3'b000, 0);

    // no learning: repeat result unchanged
    do_reset();
    fwd(3'b011, 3'b111, 0);
    bwd(3'b101, 1'b0, 3'b111, 0);
    fwd(3'b011, 3'b111, 0);
    bwd(3'b111, 1'b0, 3'b111, 0);

    // backpressure on both sides with ignored writes
    fwd(3'b011, 3'b111, 5);
    bwd(3'b111, 1'b0, 3'b111, 5);
    fwd(3'b011, 3'b111, 0);
    bwd(3'b111, 1'b0, 3'b111, 0);

    // reset while holding a learned backward result
    fwd(3'b011, 3'b111, 0);
    @(posedge clk); #1;
    bwd_data_in = 3'b101; learn_en_in = 1'b1; bwd_valid_in = 1'b1; bwd_ready_in = 1'b0;
    @(posedge clk); #1;
    bwd_valid_in = 1'b0; learn_en_in = 1'b0;
    @(negedge clk);
    check("bwd_hold_pre_rst", {31'd0, bwd_valid_out}, 1);
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_bwd_valid", {31'd0, bwd_valid_out}, 0);
    check("rst_hold_fwd_valid", {31'd0, fwd_valid_out}, 0);
    check("rst_hold_fwd_ready", {31'd0, fwd_ready_out}, 1);
    check("rst_hold_bwd_data", {29'd0, bwd_data_out}, 0);
    rst_in = 1'b0;
    fwd(3'b011, 3'b111, 0);
    bwd(3'b111, 1'b0, 3'b111, 0);

    repeat (3) @(posedge clk);
    check("fwd_q_drain", fq.size(), 0);
    check("bwd_q_drain", bq.size(), 0);
    check("fwd4_q_drain", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
